// File: rtl/mem_responder.sv
// Multicycle memory responder: latches a request, waits LATENCY edges,
// performs a word access and answers with a one-cycle MemReady pulse.
module mem_responder #(
    parameter int WORDS   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemW,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output logic        Busy
);
    localparam int AW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        memw_q;
    logic [31:0] adr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [WORDS];

    logic [AW-1:0] idx;
    logic          bad;
    logic          fire;

    assign idx  = adr_q[AW+1:2];
    assign bad  = (adr_q[1:0] != 2'b00) || (adr_q[31:AW+2] != '0);
    assign fire = (state == WAIT) && (cnt == 4'd0);

    // Storage is deliberately outside the reset domain; reset forces
    // IDLE, so an aborted access can never reach this write.
    always_ff @(posedge clk) begin
        if (fire && memw_q && !bad)
            mem[idx] <= wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            memw_q   <= 1'b0;
            adr_q    <= 32'd0;
            wdata_q  <= 32'd0;
            ReadData <= 32'd0;
            MemReady <= 1'b0;
            MemErr   <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (MemReq) begin
                        adr_q   <= Adr;
                        memw_q  <= MemW;
                        wdata_q <= WriteData;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= WAIT;
                        Busy    <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= RESP;
                        MemReady <= 1'b1;
                        MemErr   <= bad;
                        if (!memw_q && !bad)
                            ReadData <= mem[idx];
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    MemReady <= 1'b0;
                    MemErr   <= 1'b0;
                    Busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    MemReady <= 1'b0;
                    MemErr   <= 1'b0;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule
